dma_io_channel: RTL
===================

Name: dma_io_channel

Overview:
- Single DMA channel that services one IO device, sitting between the device's request/acknowledge interface and the system memory port.
- CPU programs base address, word count and direction through a small register file.
- On the device's service request, the channel takes the memory bus and moves words between device buffer and memory without CPU involvement.
- Raises a completion interrupt when the transfer ends.

Parameters:
DATA_W, 32, data word width (device and memory)
MEM_AW, 8, memory word-address width
CNT_W, 6, word-count register width (max 63 words; device buffer holds 31)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
cfg_we  in  1  CPU register write strobe
cfg_addr  in  2  register select: 0 BASE, 1 COUNT, 2 CTRL, 3 STATUS
cfg_wdata  in  DATA_W  CPU write data
cfg_rdata  out  DATA_W  combinational readback of selected register
gpio_req  in  1  device service request (device has data / wants service)
dev_ack  out  1  acknowledge to device, high for whole transfer
dev_iowrite  out  1  1 = channel writes device, 0 = channel reads device
dev_pop  out  1  one-cycle strobe: device advances to next buffer word
dev_push  out  1  one-cycle strobe: device stores dev_wdata
dev_rdata  in  DATA_W  current device buffer word (valid while dev_ack, dev_iowrite=0)
dev_wdata  out  DATA_W  word to device
bus_req  out  1  memory bus request to arbiter
bus_grant  in  1  memory bus granted
mem_req  out  1  memory access request
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready on reads
mem_ready  in  1  memory access accepted/completed this cycle
irq  out  1  completion interrupt, level, = STATUS.done

Behaviour:
- Reset: state IDLE; BASE=0, COUNT=0, CTRL=0, STATUS=0; all outputs 0.
- Registers:
  - CTRL bit0 EN, bit1 DIR (0 device->memory, 1 memory->device).
  - STATUS bit0 busy, bit1 done, bit2 abort; bits[15:8] words transferred.
  - Writing STATUS with bit1/bit2 set clears done/abort (W1C).
  - Writes to BASE/COUNT/CTRL.DIR while busy are ignored; CTRL.EN is always writable.
- States: IDLE, ARB, RD (read word), WR (write word), DONE.
- IDLE->ARB: EN=1 and (DIR=1 or gpio_req=1) and done=0. Load idx=0, remaining=COUNT, busy=1. bus_req rises the next cycle.
- COUNT=0 at start: go directly to DONE, no bus_req, no dev_ack; done=1, words=0.
- ARB: bus_req=1, dev_ack=1, dev_iowrite=DIR. On bus_grant, go to RD (DIR=0: device is the read source) or RD (DIR=1: memory is the read source).
- DIR=0 (device->memory):
  - RD/WR are merged into a single-cycle beat: mem_req=1, mem_we=1, mem_addr=BASE+idx, mem_wdata=dev_rdata.
  - dev_pop = mem_req & mem_ready.
  - On mem_ready: idx++, remaining--. Throughput is 1 word/clk when mem_ready is held high.
- DIR=1 (memory->device):
  - RD: mem_req=1, mem_we=0, mem_addr=BASE+idx. On mem_ready, capture mem_rdata into hold register and go to WR.
  - WR: dev_push=1 for one cycle, dev_wdata=hold; idx++, remaining--; return to RD.
  - Throughput is 2 clk/word minimum.
- Termination (checked after each completed word):
  - remaining=0 -> DONE.
  - DIR=0 and gpio_req=0 (device empty) -> DONE early.
- DONE: one cycle; drop bus_req, dev_ack, mem_req. Set done=1, busy=0, words=idx. Return to IDLE.
- irq stays high until done is cleared by W1C.
- bus_grant low mid-transfer: hold mem_req=0 and dev strobes=0; stall with idx/remaining frozen; resume when grant returns.
- mem_ready low: hold all mem_* outputs stable; no dev strobe.
- EN cleared while busy: finish the in-flight word (including WR of DIR=1), then go to IDLE. Set abort=1, done=0, words=idx, irq stays 0.
- Address arithmetic: BASE+idx modulo 2^MEM_AW (wraps 0xFF->0x00).
- Simultaneous cfg_we STATUS-clear and a DONE entry in the same cycle: the DONE set wins.
- reset mid-transfer: immediate return to reset state; the partially moved words are not reported.

Test Plan:
- DIR=0, BASE=0x10, COUNT=3, gpio_req high, device words 0xA,0xB,0xC, grant/ready tied 1 -> mem[0x10..0x12]=A,B,C on 3 consecutive cycles, 3 dev_pop pulses, irq=1, STATUS words=3.
- DIR=0, COUNT=5, gpio_req drops after 2nd pop -> exactly 2 memory writes, done=1, words=2, dev_ack low in the cycle after DONE.
- DIR=1, BASE=0xFE, COUNT=3, mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3 -> dev_push carries 1,2,3; addresses 0xFE,0xFF,0x00 (wrap); ≥6 cycles total.
- DIR=0, COUNT=4; hold bus_grant low for 3 cycles after word 1, mem_ready low 2 cycles on word 3 -> no lost or duplicated words; mem_addr stable during stall.
- Start with COUNT=0 -> done within 2 cycles, bus_req never asserted; W1C of done drops irq the next cycle.
- Clear EN after word 2 of COUNT=6 -> 2 (or 3 if in flight) words moved, abort=1, irq=0. Separately, assert reset mid-transfer -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/dma_io_channel_if.sv
// Device and memory-bus signal bundle of one DMA IO channel.
// master = channel side, slave = device/memory/arbiter side.
interface dma_io_channel_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
);
    logic              gpio_req;
    logic              dev_ack;
    logic              dev_iowrite;
    logic              dev_pop;
    logic              dev_push;
    logic [DATA_W-1:0] dev_rdata;
    logic [DATA_W-1:0] dev_wdata;
    logic              bus_req;
    logic              bus_grant;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  gpio_req, dev_rdata, bus_grant, mem_rdata, mem_ready,
        output dev_ack, dev_iowrite, dev_pop, dev_push, dev_wdata,
        output bus_req, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output gpio_req, dev_rdata, bus_grant, mem_rdata, mem_ready,
        input  dev_ack, dev_iowrite, dev_pop, dev_push, dev_wdata,
        input  bus_req, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dma_io_channel.sv
// Single DMA channel moving words between one IO device and memory.
// CPU programs BASE/COUNT/CTRL; completion raises a level interrupt.
module dma_io_channel #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              irq,
    dma_io_channel_if.master  io
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] R_BASE   = 2'd0;
    localparam logic [1:0] R_COUNT  = 2'd1;
    localparam logic [1:0] R_CTRL   = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic [2:0]        state;
    logic [MEM_AW-1:0] base;
    logic [CNT_W-1:0]  count;
    logic              en;
    logic              dir;
    logic              busy;
    logic              done;
    logic              abort;
    logic [CNT_W-1:0]  words;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] hold;
    logic              pend;

    logic              in_xfer;
    logic              start;
    logic              lock;
    logic              mem_req;
    logic              beat;
    logic              push;
    logic              last;
    logic              quit;
    logic              dry;
    logic              done_evt;
    logic              abort_evt;
    logic              unused_bits;

    assign unused_bits = ^cfg_wdata;

    assign in_xfer = (state == S_ARB) || (state == S_RD)
                   || (state == S_WR);
    assign start   = (state == S_IDLE) && en && !done
                   && (dir || io.gpio_req);
    assign lock    = busy || start;
    assign last    = (remaining == CNT_W'(1));

    // A started access (pend) is always carried to completion,
    // even if EN drops or the device deasserts its request.
    assign mem_req = (state == S_RD) && io.bus_grant
                   && (pend || (en && (dir || io.gpio_req)));
    assign beat    = mem_req && io.mem_ready;
    assign push    = (state == S_WR) && io.bus_grant;

    assign quit      = (state == S_RD) && !en && !pend;
    assign dry       = (state == S_RD) && !dir && !io.gpio_req
                     && !pend;
    assign done_evt  = (state == S_DONE);
    assign abort_evt = ((state == S_ARB) && !en) || quit;

    assign io.bus_req     = in_xfer;
    assign io.dev_ack     = in_xfer;
    assign io.dev_iowrite = in_xfer && dir;
    assign io.dev_pop     = beat && !dir;
    assign io.dev_push    = push;
    assign io.dev_wdata   = hold;
    assign io.mem_req     = mem_req;
    assign io.mem_we      = mem_req && !dir;
    assign io.mem_addr    = mem_req ? base + MEM_AW'(idx) : '0;
    assign io.mem_wdata   = (mem_req && !dir) ? io.dev_rdata : '0;
    assign irq            = done;

    // Register file: config writes, W1C status, transfer events.
    always_ff @(posedge clk) begin
        if (reset) begin
            base  <= '0;
            count <= '0;
            en    <= 1'b0;
            dir   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            words <= '0;
        end else begin
            if (cfg_we && cfg_addr == R_BASE && !lock)
                base <= cfg_wdata[MEM_AW-1:0];
            if (cfg_we && cfg_addr == R_COUNT && !lock)
                count <= cfg_wdata[CNT_W-1:0];
            if (cfg_we && cfg_addr == R_CTRL) begin
                en <= cfg_wdata[0];
                if (!lock)
                    dir <= cfg_wdata[1];
            end
            if (cfg_we && cfg_addr == R_STATUS) begin
                if (cfg_wdata[1])
                    done <= 1'b0;
                if (cfg_wdata[2])
                    abort <= 1'b0;
            end
            if (start)
                busy <= 1'b1;
            if (done_evt) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                words <= idx;
            end
            if (abort_evt) begin
                abort <= 1'b1;
                done  <= 1'b0;
                busy  <= 1'b0;
                words <= idx;
            end
        end
    end

    // Transfer sequencing: arbitration, word beats, termination.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            remaining <= '0;
            hold      <= '0;
            pend      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        remaining <= count;
                        pend      <= 1'b0;
                        state     <= (count == '0) ? S_DONE : S_ARB;
                    end
                end
                S_ARB: begin
                    if (!en)
                        state <= S_IDLE;
                    else if (io.bus_grant)
                        state <= S_RD;
                end
                S_RD: begin
                    if (mem_req && !io.mem_ready)
                        pend <= 1'b1;
                    else if (beat)
                        pend <= 1'b0;
                    if (quit) begin
                        state <= S_IDLE;
                    end else if (dry) begin
                        state <= S_DONE;
                    end else if (beat) begin
                        if (dir) begin
                            hold  <= io.mem_rdata;
                            state <= S_WR;
                        end else begin
                            idx       <= idx + CNT_W'(1);
                            remaining <= remaining - CNT_W'(1);
                            if (last)
                                state <= S_DONE;
                        end
                    end
                end
                S_WR: begin
                    if (push) begin
                        idx       <= idx + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        state     <= last ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational register readback.
    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            R_BASE:   cfg_rdata[MEM_AW-1:0] = base;
            R_COUNT:  cfg_rdata[CNT_W-1:0]  = count;
            R_CTRL:   cfg_rdata[1:0]        = {dir, en};
            default: begin
                cfg_rdata[2:0]      = {abort, done, busy};
                cfg_rdata[8+:CNT_W] = words;
            end
        endcase
    end
endmodule
